fetch_unit: RTL

//  Instruction fetch stage; producer side of the opcode interface into control_unit.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding control_unit.
// Holds the PC and reads the instruction memory asynchronously through
// imem_addr/imem_rdata. It issues one instruction per cycle. For two-word ops
// (LDM, SHL, SHR) it also gathers the trailing immediate word, so decode sees
// the instruction and its immediate together.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   stall               freeze PC, state and all outputs
//   redirect_valid/_pc  jump: load new PC, drop any half-gathered instruction
//   imem_addr/_rdata    instruction memory address (= pc) / read data
//   instr_out, opcode   issued instruction word and its top 5 bits
//   imm_out, imm_valid  immediate word of the issued instruction
//   instr_valid         outputs hold a real instruction
//   pc_out, pc_next     address of issued instruction / address after it
module fetch_unit #(
  parameter int unsigned            PC_W     = 16,
  parameter int unsigned            INSTR_W  = 16,
  parameter logic [PC_W-1:0]        RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [4:0]         opcode,
  output logic [INSTR_W-1:0] imm_out,
  output logic               imm_valid,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_next
);

  typedef enum logic {S_FETCH, S_IMM} state_t;

  localparam logic [4:0] OP_LDM = 5'd13;
  localparam logic [4:0] OP_SHL = 5'd30;
  localparam logic [4:0] OP_SHR = 5'd31;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic [INSTR_W-1:0] imm_out_q, imm_out_d;
  logic               imm_valid_q, imm_valid_d;
  logic               instr_valid_q, instr_valid_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic [PC_W-1:0]    pc_next_q, pc_next_d;

  logic [4:0] word_op;
  logic       two_word;

  assign word_op  = imem_rdata[INSTR_W-1 -: 5];
  assign two_word = (word_op == OP_LDM) || (word_op == OP_SHL) || (word_op == OP_SHR);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    instr_out_d   = instr_out_q;
    imm_out_d     = imm_out_q;
    imm_valid_d   = imm_valid_q;
    instr_valid_d = instr_valid_q;
    pc_out_d      = pc_out_q;
    pc_next_d     = pc_next_q;
    if (redirect_valid) begin
      // Redirect beats stall: the half-gathered instruction is thrown away.
      pc_d          = redirect_pc;
      state_d       = S_FETCH;
      instr_valid_d = 1'b0;
      imm_valid_d   = 1'b0;
      instr_out_d   = '0;
    end else if (!stall) begin
      unique case (state_q)
        S_FETCH: begin
          ir_d = imem_rdata;
          pc_d = pc_q + 1'b1;
          if (two_word) begin
            state_d       = S_IMM;
            instr_valid_d = 1'b0;
          end else begin
            instr_out_d   = imem_rdata;
            instr_valid_d = 1'b1;
            imm_valid_d   = 1'b0;
            pc_out_d      = pc_q;
            pc_next_d     = pc_q + 1'b1;
          end
        end
        S_IMM: begin
          // pc already points at the immediate, so the first word sits at pc-1.
          imm_out_d     = imem_rdata;
          pc_d          = pc_q + 1'b1;
          state_d       = S_FETCH;
          instr_out_d   = ir_q;
          instr_valid_d = 1'b1;
          imm_valid_d   = 1'b1;
          pc_out_d      = pc_q - 1'b1;
          pc_next_d     = pc_q + 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      instr_out_q   <= '0;
      imm_out_q     <= '0;
      imm_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_out_q      <= '0;
      pc_next_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instr_out_q   <= instr_out_d;
      imm_out_q     <= imm_out_d;
      imm_valid_q   <= imm_valid_d;
      instr_valid_q <= instr_valid_d;
      pc_out_q      <= pc_out_d;
      pc_next_q     <= pc_next_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_out   = instr_out_q;
  assign opcode      = instr_out_q[INSTR_W-1 -: 5];
  assign imm_out     = imm_out_q;
  assign imm_valid   = imm_valid_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_out_q;
  assign pc_next     = pc_next_q;

endmodule
